// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: opcodes, NZCV flag bit positions and FSM states.
package alu_pipe_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier: low WIDTH bits of a*b, one partial product per cycle.
// The final partial product is folded in combinationally so 'product' is valid while 'done'.
module alu_pipe_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] partial_s;

  assign partial_s = mplier_r[0] ? mcand_r : {WIDTH{1'b0}};
  assign product   = acc_r + partial_s;
  assign done      = busy_r && (cnt_r == CW'(WIDTH - 1));

  // Operand load, per-cycle accumulate/shift, and hold at final count until acknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {WIDTH{1'b0}};
    end else if (busy_r && !done) begin
      acc_r    <= product;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else if (done && ack) begin
      busy_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else begin
      busy_r   <= busy_r;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready handshake and NZCV flags.
// Define ALU_MUL_EN to enable the iterative multiplier on opcode 101 (illegal otherwise).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  state_t           state_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_result_r;
  logic [3:0]       out_flags_r;
  logic             out_err_r;

  logic             can_load_s;
  logic             accept_s;
  logic             is_mul_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic             alu_err_s;
  logic [3:0]       alu_flags_s;

  assign can_load_s = !out_valid_r || out_ready;
  assign in_ready   = (state_r == ST_IDLE) && can_load_s;
  assign accept_s   = in_valid && in_ready;

  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_flags  = out_flags_r;
  assign out_err    = out_err_r;

  // Subtraction as A + ~B + 1 so the carry out is the unsigned no-borrow flag
  assign sum_s  = {1'b0, in_a} + {1'b0, in_b};
  assign diff_s = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle result and flags for the non-iterative opcodes
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_s[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_s[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res_s = in_a & in_b;
      OP_OR:   alu_res_s = in_a | in_b;
      OP_MOV:  alu_res_s = in_b;
      default: alu_err_s = 1'b1;
    endcase
    alu_flags_s         = 4'b0000;
    alu_flags_s[FLAG_N] = alu_res_s[WIDTH-1];
    alu_flags_s[FLAG_Z] = (alu_res_s == {WIDTH{1'b0}});
    alu_flags_s[FLAG_C] = alu_c_s;
    alu_flags_s[FLAG_V] = alu_v_s;
  end

`ifdef ALU_MUL_EN
  logic             mul_ack_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;
  logic [3:0]       mul_flags_s;

  assign is_mul_s  = (in_op == OP_MUL);
  assign mul_ack_s = (state_r == ST_MUL) && can_load_s;

  // Multiply only produces N and Z; C and V are forced clear
  always_comb begin
    mul_flags_s         = 4'b0000;
    mul_flags_s[FLAG_N] = mul_prod_s[WIDTH-1];
    mul_flags_s[FLAG_Z] = (mul_prod_s == {WIDTH{1'b0}});
  end

  alu_pipe_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept_s && is_mul_s),
    .a       (in_a),
    .b       (in_b),
    .ack     (mul_ack_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );
`else
  assign is_mul_s = 1'b0;
`endif

  // Control FSM and output register; the output only drops when drained without a replacement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      out_valid_r  <= 1'b0;
      out_result_r <= {WIDTH{1'b0}};
      out_flags_r  <= 4'b0000;
      out_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && is_mul_s) begin
            state_r     <= ST_MUL;
            out_valid_r <= 1'b0;
          end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= alu_res_s;
            out_flags_r  <= alu_flags_s;
            out_err_r    <= alu_err_s;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          if (mul_ack_s && mul_done_s) begin
            state_r      <= ST_IDLE;
            out_valid_r  <= 1'b1;
            out_result_r <= mul_prod_s;
            out_flags_r  <= mul_flags_s;
            out_err_r    <= 1'b0;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
`endif
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe (WIDTH=32); follows ALU_MUL_EN for opcode 101 expectations.
module tb_alu_pipe;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [3:0]    out_flags;
  logic          out_err;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         err;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one operation, queue its expected result, wait (bounded) for acceptance
  task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic [3:0] fl,
                       input logic err, output int waited);
    exp_t e;
    e.res = res; e.fl = fl; e.err = err; e.tag = tag;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    sb.push_back(e);
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      waited++;
      if (in_ready) break;
    end
    chk({tag, "_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare each result as the consumer takes it
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_result"}, 64'(out_result), 64'(e.res));
        chk({e.tag, "_flags"}, 64'(out_flags), 64'(e.fl));
        chk({e.tag, "_err"}, 64'(out_err), 64'(e.err));
      end
    end
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_flags", 64'(out_flags), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    issue("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1'b0, w);
    chk("add_latency", 64'(out_valid), 64'd1);
    issue("add_carry", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1'b0, w);
    issue("sub_eq", 3'b001, 32'd5, 32'd5, 32'h0000_0000, 4'b0110, 1'b0, w);
    issue("sub_neg", 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000, 1'b0, w);
    issue("sub_ovf", 3'b001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011, 1'b0, w);

    issue("and", 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 1'b0, w);
    chk("b2b_and", 64'(w), 64'd1);
    issue("or", 3'b011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000, 1'b0, w);
    chk("b2b_or", 64'(w), 64'd1);
    issue("mov", 3'b100, 32'h0000_0123, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1'b0, w);
    chk("b2b_mov", 64'(w), 64'd1);
    issue("ill", 3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 4'b0100, 1'b1, w);
    chk("b2b_ill", 64'(w), 64'd1);
    chk("ill_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    chk("drained_idle", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    issue("bp_add", 3'b000, 32'd1, 32'd2, 32'd3, 4'b0000, 1'b0, w);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(out_result), 64'd3);
      chk("bp_flags", 64'(out_flags), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue("bp_next", 3'b011, 32'h0000_0005, 32'h0000_000A, 32'h0000_000F, 4'b0000, 1'b0, w);
    chk("bp_same_cycle", 64'(w), 64'd1);
    chk("bp_valid_kept", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    issue("mul", 3'b101, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 4'b0000, 1'b0, w);
    for (int j = 0; j < W; j++) begin
      chk("mul_busy_valid", 64'(out_valid), 64'd0);
      chk("mul_busy_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("mul_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    issue("mul_abort", 3'b101, 32'd3, 32'd4, 32'd12, 4'b0000, 1'b0, w);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy", 64'(in_ready), 64'd0);
`else
    issue("mul_ill", 3'b101, 32'h0001_0000, 32'h0001_0001, 32'h0000_0000, 4'b0100, 1'b1, w);
    chk("mul_ill_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue("pend_abort", 3'b000, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0, w);
    chk("abort_pending", 64'(out_valid), 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(out_result), 64'd0);
    chk("abort_flags", 64'(out_flags), 64'd0);
    chk("abort_err", 64'(out_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_no_partial", 64'(out_valid), 64'd0);
    issue("post_rst_add", 3'b000, 32'd2, 32'd2, 32'd4, 4'b0000, 1'b0, w);
    chk("post_rst_latency", 64'(out_valid), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the single-cycle datapath ALU. Accepts one operation per cycle over a valid/ready handshake, computes ADD/SUB/AND/OR/MOV on WIDTH-bit operands with ARM-style NZCV flags, and presents a registered result. It sits between decode/register-read and write-back in the multicycle/pipelined core. An optional iterative multiplier stalls the input side while it runs.

## Interface
- WIDTH, 32, operand/result width (≥4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- in_op  in  3  opcode
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts the result
- out_result  out  WIDTH  result
- out_flags  out  4  {N,Z,C,V}
- out_err  out  1  opcode was illegal

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MOV (result = B), 101 MUL (only with macro), others illegal.
- Accept = in_valid & in_ready; operands/opcode captured on the accepting edge.
- ADD: {C,result} = A + B (WIDTH+1 bits); V = sign(A)==sign(B) && sign(result)!=sign(A).
- SUB: result = A + ~B + 1; C = 1 when A ≥ B unsigned (no borrow); V = sign(A)!=sign(B) && sign(result)!=sign(A).
- AND/OR/MOV/MUL: C=0, V=0.
- All ops: N = result[WIDTH-1], Z = (result == 0).
- Illegal opcode: result 0, flags {0,1,0,0}, out_err=1; otherwise out_err=0.
- FSM: IDLE (accepts), MUL (iterating). IDLE→MUL on accepted MUL; MUL→IDLE when iteration count reaches WIDTH, loading the output register.
- in_ready = (state==IDLE) && (!out_valid || out_ready).

## Timing
- Reset: out_valid=0, out_result=0, out_flags=0, out_err=0, state IDLE, counter 0; in_ready=1 after reset.
- Non-MUL latency: 1 cycle (accept at edge k, out_valid high after edge k).
- Back-to-back: with out_ready held high, one result per cycle, no bubbles.
- Backpressure: out_valid/out_result/out_flags/out_err stable while out_valid & !out_ready; in_ready low in that case.
- Simultaneous drain and accept in the same cycle: new result replaces old; out_valid stays 1.
- MUL: accept at edge k; out_valid high after edge k+WIDTH; in_ready low from edge k+1 until the result register is drained/replaceable.
- Output register loads from MUL only if empty or draining; otherwise FSM holds in MUL at final count.
- rst_n assertion mid-MUL or with pending output: immediate abort, all outputs to reset values; no partial result.

## Configuration
- ALU_MUL_EN defined: opcode 101 performs shift-add multiply, low WIDTH bits of A*B, WIDTH-cycle iteration.
- Undefined: MUL state and multiplier logic absent; opcode 101 is illegal (out_err=1, 1-cycle latency).

## Structure
- Package alu_pipe_pkg: opcode constants (ADD, SUB, AND, OR, MOV, MUL), flag bit indices (N=3, Z=2, C=1, V=0), FSM state enum.
- Existing result-type/arith opcode values keep their encodings.
- Sub-module alu_pipe_mul: iterative shift-add multiplier with start/done, instantiated only under ALU_MUL_EN.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, flags N=1 Z=0 C=0 V=1, one cycle later.
- SUB 5-5 -> result 0, Z=1 C=1; SUB 3-5 -> 0xFFFFFFFE, N=1 C=0 V=0.
- Stream AND, OR, MOV, op 111 back-to-back with out_ready=1 -> four results on consecutive cycles; op 111 gives 0, flags 0100, out_err=1.
- out_ready=0 for 3 cycles after ADD 1+2 -> result 3 held stable, in_ready=0; released -> accepted next op same cycle.
- ALU_MUL_EN, MUL 0x10000×0x10001 -> 0x00010000 after 32 cycles, in_ready low throughout; without macro -> out_err=1 after 1 cycle.
- Drop rst_n during MUL cycle 10 -> out_valid=0, in_ready=1 after release, next ADD 2+2 returns 4.
